// File: rtl/il1_axi_pkg.sv
// il1_axi_pkg: shared definitions for the IL1 AXI read responder.
//   - AXI burst-type and response encodings
//   - responder FSM state encoding (2 bits)
//   - R-beat record held in the output skid buffer
//   - beat-address and burst-legality helpers
package il1_axi_pkg;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;
   localparam logic [1:0] BURST_RSVD  = 2'b11;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   localparam int BUS_DW = 64;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2
   } rd_state_e;

   typedef struct packed {
      logic [BUS_DW-1:0] data;
      logic [1:0]        resp;
      logic              last;
   } r_beat_t;

   // Reserved burst type, or WRAP with a length that is not 2/4/8/16 beats.
   function automatic logic burst_illegal(input logic [1:0] burst,
                                          input logic [7:0] len);
      logic wrap_len_ok;
      wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
      return (burst == BURST_RSVD) || ((burst == BURST_WRAP) && !wrap_len_ok);
   endfunction

   // Byte address of beat idx. Computed at 64 bits; the caller truncates to
   // its address width, which gives the INCR modulo-2^AW wrap for free.
   // For legal WRAP lengths (len+1)*8-1 == {len,3'b111} is a low-bit mask.
   function automatic logic [63:0] beat_addr(input logic [63:0] start,
                                             input logic [7:0]  len,
                                             input logic [1:0]  burst,
                                             input logic [7:0]  idx);
      logic [63:0] step;
      logic [63:0] span_m1;
      logic [63:0] low;
      logic [63:0] res;
      step    = {53'd0, idx, 3'b000};
      span_m1 = {53'd0, len, 3'b111};
      low     = start & ~span_m1;
      case (burst)
         BURST_FIXED: res = start;
         BURST_WRAP:  res = low + ((start + step) & span_m1);
         default:     res = start + step;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/rd_skid_buf.sv
// rd_skid_buf: 2-entry FIFO of R beats between the SRAM read stage and the
// R channel. Entry 0 is the head and drives the R outputs straight from
// flops; entry 1 catches a beat arriving while the head is stalled.
//   clk, rst    clock, synchronous active-high reset
//   push, push_beat   beat from the SRAM stage (never pushed when full)
//   pop         head consumed (RVALID & RREADY)
//   head_valid, head  registered head entry
//   occ         number of valid entries (0..2)
module rd_skid_buf
   import il1_axi_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       push,
   input  r_beat_t    push_beat,
   input  logic       pop,
   output logic       head_valid,
   output r_beat_t    head,
   output logic [1:0] occ
);

   r_beat_t slot0_q, slot0_d;
   r_beat_t slot1_q, slot1_d;
   logic    vld0_q, vld0_d;
   logic    vld1_q, vld1_d;

   always_comb begin
      slot0_d = slot0_q;
      slot1_d = slot1_q;
      vld0_d  = vld0_q;
      vld1_d  = vld1_q;
      if (pop) begin
         if (vld1_q) begin
            slot0_d = slot1_q;
            slot1_d = '0;
            vld1_d  = 1'b0;
            if (push) begin
               slot1_d = push_beat;
               vld1_d  = 1'b1;
            end
         end else if (push) begin
            slot0_d = push_beat;
         end else begin
            // Empty head is cleared so RLAST never lingers without RVALID.
            slot0_d = '0;
            vld0_d  = 1'b0;
         end
      end else if (push) begin
         if (!vld0_q) begin
            slot0_d = push_beat;
            vld0_d  = 1'b1;
         end else begin
            slot1_d = push_beat;
            vld1_d  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         slot0_q <= '0;
         slot1_q <= '0;
         vld0_q  <= 1'b0;
         vld1_q  <= 1'b0;
      end else begin
         slot0_q <= slot0_d;
         slot1_q <= slot1_d;
         vld0_q  <= vld0_d;
         vld1_q  <= vld1_d;
      end
   end

   assign head_valid = vld0_q;
   assign head       = slot0_q;
   assign occ        = {1'b0, vld0_q} + {1'b0, vld1_q};

endmodule

// File: rtl/il1_axi_rd_responder.sv
// il1_axi_rd_responder: AXI4 read-channel slave for the IL1 fetch bus.
// One burst at a time is read from an inline word-addressed synchronous
// SRAM and returned through a 2-deep skid buffer.
//   CLK, RST                  clock, synchronous active-high reset
//   S_AR*                     address channel (ARADDR[2:0] ignored)
//   S_R*                      read data channel, all outputs registered
//   init_we/init_idx/init_data  SRAM preload port, accepted in any state
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | ARREADY high, waiting for an AR handshake
// ST_ISSUE | one SRAM read per cycle while the skid buffer has room
// ST_DRAIN | all reads issued, waiting for the RLAST handshake
module il1_axi_rd_responder
   import il1_axi_pkg::*;
#(
   parameter int              DW        = 64,
   parameter int              AW        = 32,
   parameter int              MEM_DEPTH = 1024,
   parameter logic [AW-1:0]   BASE_ADDR = 32'h8000_0000,
   localparam int             IDXW      = $clog2(MEM_DEPTH)
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [AW-1:0]    S_ARADDR,
   input  logic [7:0]       S_ARLEN,
   input  logic [1:0]       S_ARBURST,
   input  logic             S_ARVALID,
   output logic             S_ARREADY,
   output logic [DW-1:0]    S_RDATA,
   output logic [1:0]       S_RRESP,
   output logic             S_RLAST,
   output logic             S_RVALID,
   input  logic             S_RREADY,
   input  logic             init_we,
   input  logic [IDXW-1:0]  init_idx,
   input  logic [DW-1:0]    init_data
);

   localparam logic [AW:0] MEM_LO = {1'b0, BASE_ADDR};
   localparam logic [AW:0] MEM_HI = {1'b0, BASE_ADDR} + (AW+1)'(MEM_DEPTH * 8);

   rd_state_e     state_q, state_d;
   logic          ar_ready_q, ar_ready_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [7:0]    len_q, len_d;
   logic [7:0]    idx_q, idx_d;
   logic [1:0]    burst_q, burst_d;
   logic          rd_vld_q, rd_vld_d;
   logic          rd_last_q, rd_last_d;
   logic          rd_err_q, rd_err_d;
   logic [DW-1:0] rd_data_q;
   logic [DW-1:0] mem [MEM_DEPTH];

   logic [AW-1:0]   cur_addr;
   logic [IDXW-1:0] rd_idx;
   logic            in_range;
   logic            issue;
   logic            pop;
   logic            slot_free;
   logic [1:0]      occ;
   r_beat_t         head;
   r_beat_t         push_beat;
   logic            head_valid;
   logic            unused_araddr;

   assign unused_araddr = ^S_ARADDR[2:0];

   assign cur_addr = AW'(beat_addr(64'(addr_q), len_q, burst_q, idx_q));
   assign rd_idx   = cur_addr[IDXW+2:3];
   assign in_range = ({1'b0, cur_addr} >= MEM_LO) && ({1'b0, cur_addr} < MEM_HI);

   assign pop = head_valid & S_RREADY;
   // Room is counted after this cycle's pop so a ready master sees no bubbles,
   // while buffered plus in-flight beats never exceed two.
   assign slot_free = (({1'b0, occ} + {2'b0, rd_vld_q}) < (3'd2 + {2'b0, pop}));

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      len_d     = len_q;
      burst_d   = burst_q;
      idx_d     = idx_q;
      issue     = 1'b0;
      rd_last_d = rd_last_q;
      rd_err_d  = rd_err_q;
      case (state_q)
         ST_IDLE: begin
            if (ar_ready_q && S_ARVALID) begin
               addr_d  = {S_ARADDR[AW-1:3], 3'b000};
               len_d   = S_ARLEN;
               burst_d = S_ARBURST;
               idx_d   = 8'd0;
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (slot_free) begin
               issue     = 1'b1;
               rd_last_d = (idx_q == len_q);
               rd_err_d  = burst_illegal(burst_q, len_q) || !in_range;
               if (idx_q == len_q) begin
                  state_d = ST_DRAIN;
               end else begin
                  idx_d = idx_q + 8'd1;
               end
            end
         end
         ST_DRAIN: begin
            if (pop && head.last) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      rd_vld_d   = issue;
      ar_ready_d = (state_d == ST_IDLE);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= ST_IDLE;
         ar_ready_q <= 1'b0;
         addr_q     <= '0;
         len_q      <= '0;
         burst_q    <= '0;
         idx_q      <= '0;
         rd_vld_q   <= 1'b0;
         rd_last_q  <= 1'b0;
         rd_err_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         ar_ready_q <= ar_ready_d;
         addr_q     <= addr_d;
         len_q      <= len_d;
         burst_q    <= burst_d;
         idx_q      <= idx_d;
         rd_vld_q   <= rd_vld_d;
         rd_last_q  <= rd_last_d;
         rd_err_q   <= rd_err_d;
      end
   end

   // Read-first: a same-edge preload to the read index returns the old word.
   always_ff @(posedge CLK) begin
      if (init_we) begin
         mem[init_idx] <= init_data;
      end
      if (issue) begin
         rd_data_q <= mem[rd_idx];
      end
   end

   always_comb begin
      push_beat.data = rd_err_q ? '0 : rd_data_q;
      push_beat.resp = rd_err_q ? RESP_SLVERR : RESP_OKAY;
      push_beat.last = rd_last_q;
   end

   rd_skid_buf u_skid (
      .clk        (CLK),
      .rst        (RST),
      .push       (rd_vld_q),
      .push_beat  (push_beat),
      .pop        (pop),
      .head_valid (head_valid),
      .head       (head),
      .occ        (occ)
   );

   assign S_ARREADY = ar_ready_q;
   assign S_RVALID  = head_valid;
   assign S_RDATA   = head.data;
   assign S_RRESP   = head.resp;
   assign S_RLAST   = head.last;

endmodule

// File: tb/tb_il1_axi_rd_responder.sv
module tb_il1_axi_rd_responder;

   localparam int          MEM_DEPTH = 1024;
   localparam logic [31:0] BASE      = 32'h8000_0000;
   localparam longint      BASE_L    = 64'h8000_0000;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic [31:0] S_ARADDR = '0;
   logic [7:0]  S_ARLEN = '0;
   logic [1:0]  S_ARBURST = '0;
   logic        S_ARVALID = 1'b0;
   logic        S_ARREADY;
   logic [63:0] S_RDATA;
   logic [1:0]  S_RRESP;
   logic        S_RLAST;
   logic        S_RVALID;
   logic        S_RREADY = 1'b0;
   logic        init_we = 1'b0;
   logic [9:0]  init_idx = '0;
   logic [63:0] init_data = '0;

   always #5 CLK = ~CLK;

   il1_axi_rd_responder dut (
      .CLK       (CLK),
      .RST       (RST),
      .S_ARADDR  (S_ARADDR),
      .S_ARLEN   (S_ARLEN),
      .S_ARBURST (S_ARBURST),
      .S_ARVALID (S_ARVALID),
      .S_ARREADY (S_ARREADY),
      .S_RDATA   (S_RDATA),
      .S_RRESP   (S_RRESP),
      .S_RLAST   (S_RLAST),
      .S_RVALID  (S_RVALID),
      .S_RREADY  (S_RREADY),
      .init_we   (init_we),
      .init_idx  (init_idx),
      .init_data (init_data)
   );

   int errors = 0;
   int checks = 0;

   logic [63:0] model_mem [MEM_DEPTH];
   logic [63:0] got_data[$];
   logic [1:0]  got_resp[$];
   logic        got_last[$];
   int          lat;
   int          hold_viol;
   int          timed_out;
   logic        ar_after;
   logic        rv_after;

   // Reference: beat i of a burst, straight from the AXI address rules.
   function automatic void exp_beat(input logic [31:0] addr, input int len,
                                    input logic [1:0] burst, input int i,
                                    output logic [63:0] d, output logic [1:0] r);
      longint a, b, low, ba;
      bit     bad;
      a   = {32'd0, addr[31:3], 3'b000};
      bad = (burst == 2'b11) ||
            (burst == 2'b10 && !(len == 1 || len == 3 || len == 7 || len == 15));
      case (burst)
         2'b00: ba = a;
         2'b10: begin
            b   = longint'((len + 1) * 8);
            low = (a / b) * b;
            ba  = low + ((a - low + longint'(8 * i)) % b);
         end
         default: ba = (a + longint'(8 * i)) % (64'd1 << 32);
      endcase
      if (bad || ba < BASE_L || ba >= BASE_L + longint'(8 * MEM_DEPTH)) begin
         d = '0;
         r = 2'b10;
      end else begin
         d = model_mem[int'((ba - BASE_L) / 8)];
         r = 2'b00;
      end
   endfunction

   task automatic write_word(input int idx, input logic [63:0] data);
      init_we   = 1'b1;
      init_idx  = 10'(idx);
      init_data = data;
      model_mem[idx] = data;
      @(posedge CLK); #1;
      init_we = 1'b0;
   endtask

   // Issues one AR and collects the R beats. rmode: 0 ready, 1 random, 2 fixed
   // pattern 1,0,0,1,0,1. wr_edge>0 drives a preload at that edge after the
   // AR handshake edge.
   task automatic run_burst(input logic [31:0] addr, input int len, input logic [1:0] burst,
                            input int rmode, input int wr_edge,
                            input int wr_idx, input logic [63:0] wr_data);
      int          edges, budget, k;
      logic        stalled;
      logic [63:0] pd;
      logic [1:0]  pr;
      logic        pl;
      logic [5:0]  pat;
      pat = 6'b101001;
      got_data.delete();
      got_resp.delete();
      got_last.delete();
      lat = -1; hold_viol = 0; timed_out = 0; stalled = 1'b0;
      pd = '0; pr = '0; pl = 1'b0;
      S_ARADDR = addr; S_ARLEN = 8'(len); S_ARBURST = burst; S_ARVALID = 1'b1;
      k = 0;
      while (S_ARREADY !== 1'b1 && k < 50) begin
         @(posedge CLK); #1; k++;
      end
      if (S_ARREADY !== 1'b1) begin
         timed_out = 1;
         S_ARVALID = 1'b0;
         return;
      end
      @(posedge CLK); #1;
      S_ARVALID = 1'b0;
      edges = 0;
      budget = 60 + 6 * (len + 1);
      while (got_data.size() < len + 1 && edges < budget) begin
         if (stalled && (S_RVALID !== 1'b1 || S_RDATA !== pd || S_RRESP !== pr || S_RLAST !== pl))
            hold_viol++;
         if (lat < 0 && S_RVALID === 1'b1) lat = edges;
         case (rmode)
            0:       S_RREADY = 1'b1;
            1:       S_RREADY = 1'($urandom_range(0, 1));
            default: S_RREADY = pat[edges % 6];
         endcase
         init_we   = (wr_edge > 0 && edges == wr_edge - 1);
         init_idx  = 10'(wr_idx);
         init_data = wr_data;
         if (S_RVALID === 1'b1 && S_RREADY) begin
            got_data.push_back(S_RDATA);
            got_resp.push_back(S_RRESP);
            got_last.push_back(S_RLAST);
         end
         stalled = (S_RVALID === 1'b1) && !S_RREADY;
         pd = S_RDATA; pr = S_RRESP; pl = S_RLAST;
         @(posedge CLK); #1; edges++;
      end
      init_we = 1'b0;
      if (got_data.size() < len + 1) timed_out = 1;
      ar_after = S_ARREADY;
      rv_after = S_RVALID;
      S_RREADY = 1'b1;
   endtask

   task automatic test_reset();
      RST = 1'b1;
      repeat (3) @(posedge CLK);
      #1;
      checks++; if (S_ARREADY !== 1'b0) begin errors++; $display("FAIL rst_arready got=%b want=0", S_ARREADY); end
      checks++; if (S_RVALID !== 1'b0) begin errors++; $display("FAIL rst_rvalid got=%b want=0", S_RVALID); end
      checks++; if (S_RLAST !== 1'b0) begin errors++; $display("FAIL rst_rlast got=%b want=0", S_RLAST); end
      checks++; if (S_RRESP !== 2'b00) begin errors++; $display("FAIL rst_rresp got=%b want=00", S_RRESP); end
      checks++; if (S_RDATA !== 64'd0) begin errors++; $display("FAIL rst_rdata got=%h want=0", S_RDATA); end
      RST = 1'b0;
      @(posedge CLK); #1;
      checks++; if (S_ARREADY !== 1'b1) begin errors++; $display("FAIL rst_arready_rise got=%b want=1", S_ARREADY); end
   endtask

   task automatic preload_all();
      for (int i = 0; i < MEM_DEPTH; i++) write_word(i, {$urandom, $urandom});
   endtask

   task automatic test_incr_basic();
      logic [63:0] exp [4];
      exp[0] = 64'h1111_1111_1111_1111; exp[1] = 64'h2222_2222_2222_2222;
      exp[2] = 64'h3333_3333_3333_3333; exp[3] = 64'h4444_4444_4444_4444;
      for (int i = 0; i < 4; i++) write_word(i, exp[i]);
      run_burst(BASE, 3, 2'b01, 0, 0, 0, 64'd0);
      checks++; if (timed_out != 0 || got_data.size() != 4) begin errors++; $display("FAIL incr_count got=%0d want=4 timeout=%0d", got_data.size(), timed_out); end
      checks++; if (lat != 2) begin errors++; $display("FAIL incr_latency got=%0d want=2", lat); end
      for (int i = 0; i < got_data.size() && i < 4; i++) begin
         checks++; if (got_data[i] !== exp[i]) begin errors++; $display("FAIL incr_data beat=%0d got=%h want=%h", i, got_data[i], exp[i]); end
         checks++; if (got_resp[i] !== 2'b00) begin errors++; $display("FAIL incr_resp beat=%0d got=%b want=00", i, got_resp[i]); end
         checks++; if (got_last[i] !== (i == 3)) begin errors++; $display("FAIL incr_last beat=%0d got=%b want=%b", i, got_last[i], i == 3); end
      end
      checks++; if (ar_after !== 1'b1) begin errors++; $display("FAIL incr_arready_after got=%b want=1", ar_after); end
      checks++; if (rv_after !== 1'b0) begin errors++; $display("FAIL incr_rvalid_after got=%b want=0", rv_after); end
   endtask

   task automatic test_wrap();
      int order [4];
      order[0] = 2; order[1] = 3; order[2] = 0; order[3] = 1;
      run_burst(BASE + 32'h10, 3, 2'b10, 0, 0, 0, 64'd0);
      checks++; if (timed_out != 0 || got_data.size() != 4) begin errors++; $display("FAIL wrap_count got=%0d want=4", got_data.size()); end
      for (int i = 0; i < got_data.size() && i < 4; i++) begin
         checks++; if (got_data[i] !== model_mem[order[i]]) begin errors++; $display("FAIL wrap_data beat=%0d got=%h want=%h", i, got_data[i], model_mem[order[i]]); end
         checks++; if (got_last[i] !== (i == 3)) begin errors++; $display("FAIL wrap_last beat=%0d got=%b want=%b", i, got_last[i], i == 3); end
      end
   endtask

   task automatic test_backpressure();
      run_burst(BASE, 3, 2'b01, 2, 0, 0, 64'd0);
      checks++; if (timed_out != 0 || got_data.size() != 4) begin errors++; $display("FAIL bp_count got=%0d want=4", got_data.size()); end
      for (int i = 0; i < got_data.size() && i < 4; i++) begin
         checks++; if (got_data[i] !== model_mem[i]) begin errors++; $display("FAIL bp_data beat=%0d got=%h want=%h", i, got_data[i], model_mem[i]); end
         checks++; if (got_last[i] !== (i == 3)) begin errors++; $display("FAIL bp_last beat=%0d got=%b want=%b", i, got_last[i], i == 3); end
      end
      checks++; if (hold_viol != 0) begin errors++; $display("FAIL bp_hold_stable got=%0d changes want=0", hold_viol); end
      checks++; if (rv_after !== 1'b0) begin errors++; $display("FAIL bp_extra_beat got=%b want=0", rv_after); end
   endtask

   task automatic test_boundary();
      run_burst(BASE + 32'(8 * (MEM_DEPTH - 1)), 1, 2'b01, 0, 0, 0, 64'd0);
      checks++; if (timed_out != 0 || got_data.size() != 2) begin errors++; $display("FAIL bound_count got=%0d want=2", got_data.size()); end
      if (got_data.size() == 2) begin
         checks++; if (got_data[0] !== model_mem[MEM_DEPTH-1] || got_resp[0] !== 2'b00 || got_last[0] !== 1'b0) begin
            errors++; $display("FAIL bound_beat0 got=%h/%b/%b want=%h/00/0", got_data[0], got_resp[0], got_last[0], model_mem[MEM_DEPTH-1]); end
         checks++; if (got_data[1] !== 64'd0 || got_resp[1] !== 2'b10 || got_last[1] !== 1'b1) begin
            errors++; $display("FAIL bound_beat1 got=%h/%b/%b want=0/10/1", got_data[1], got_resp[1], got_last[1]); end
      end
   endtask

   task automatic test_rsvd_burst();
      run_burst(BASE, 2, 2'b11, 0, 0, 0, 64'd0);
      checks++; if (timed_out != 0 || got_data.size() != 3) begin errors++; $display("FAIL rsvd_count got=%0d want=3", got_data.size()); end
      for (int i = 0; i < got_data.size() && i < 3; i++) begin
         checks++; if (got_data[i] !== 64'd0 || got_resp[i] !== 2'b10 || got_last[i] !== (i == 2)) begin
            errors++; $display("FAIL rsvd_beat beat=%0d got=%h/%b/%b want=0/10/%b", i, got_data[i], got_resp[i], got_last[i], i == 2); end
      end
   endtask

   // FIXED burst on word 5; beat i is read at edge i+1, so a preload at edge 3
   // collides with beat 2 (old data) and beats 3.. see the new word.
   task automatic test_preload_read_first();
      logic [63:0] old_w, new_w, want;
      old_w = model_mem[5];
      new_w = ~old_w;
      run_burst(BASE + 32'd40, 7, 2'b00, 0, 3, 5, new_w);
      model_mem[5] = new_w;
      checks++; if (timed_out != 0 || got_data.size() != 8) begin errors++; $display("FAIL rfirst_count got=%0d want=8", got_data.size()); end
      for (int i = 0; i < got_data.size() && i < 8; i++) begin
         want = (i < 3) ? old_w : new_w;
         checks++; if (got_data[i] !== want) begin errors++; $display("FAIL rfirst_data beat=%0d got=%h want=%h", i, got_data[i], want); end
      end
   endtask

   task automatic test_random();
      logic [31:0] addr;
      logic [1:0]  burst, er;
      logic [63:0] ed;
      int          len, sel;
      for (int n = 0; n < 25; n++) begin
         addr  = BASE + 32'($urandom_range(0, 8 * 1100)) - 32'd320;
         sel   = $urandom_range(0, 5);
         case (sel)
            0: len = 0;
            1: len = 1;
            2: len = 3;
            3: len = 7;
            4: len = 15;
            default: len = $urandom_range(0, 20);
         endcase
         burst = 2'($urandom_range(0, 3));
         run_burst(addr, len, burst, $urandom_range(0, 1), 0, 0, 64'd0);
         checks++; if (timed_out != 0 || got_data.size() != len + 1) begin
            errors++; $display("FAIL rnd_count iter=%0d got=%0d want=%0d", n, got_data.size(), len + 1); end
         checks++; if (hold_viol != 0) begin errors++; $display("FAIL rnd_hold iter=%0d got=%0d want=0", n, hold_viol); end
         for (int i = 0; i < got_data.size() && i <= len; i++) begin
            exp_beat(addr, len, burst, i, ed, er);
            checks++; if (got_data[i] !== ed || got_resp[i] !== er || got_last[i] !== (i == len)) begin
               errors++;
               $display("FAIL rnd_beat iter=%0d addr=%h len=%0d burst=%b beat=%0d got=%h/%b/%b want=%h/%b/%b",
                        n, addr, len, burst, i, got_data[i], got_resp[i], got_last[i], ed, er, i == len);
            end
         end
      end
   endtask

   task automatic test_mid_reset();
      int k;
      S_ARADDR = BASE; S_ARLEN = 8'd7; S_ARBURST = 2'b01; S_ARVALID = 1'b1; S_RREADY = 1'b1;
      k = 0;
      while (S_ARREADY !== 1'b1 && k < 50) begin @(posedge CLK); #1; k++; end
      checks++; if (S_ARREADY !== 1'b1) begin errors++; $display("FAIL mrst_ar_wait got=%b want=1", S_ARREADY); end
      @(posedge CLK); #1;
      S_ARVALID = 1'b0;
      repeat (4) @(posedge CLK);
      #1;
      checks++; if (S_RVALID !== 1'b1) begin errors++; $display("FAIL mrst_midburst_rvalid got=%b want=1", S_RVALID); end
      RST = 1'b1;
      @(posedge CLK); #1;
      checks++; if (S_RVALID !== 1'b0 || S_RLAST !== 1'b0) begin errors++; $display("FAIL mrst_clear got=%b/%b want=0/0", S_RVALID, S_RLAST); end
      checks++; if (S_ARREADY !== 1'b0) begin errors++; $display("FAIL mrst_arready_in_rst got=%b want=0", S_ARREADY); end
      RST = 1'b0;
      @(posedge CLK); #1;
      checks++; if (S_ARREADY !== 1'b1) begin errors++; $display("FAIL mrst_arready_after got=%b want=1", S_ARREADY); end
      run_burst(BASE + 32'd56, 0, 2'b00, 0, 0, 0, 64'd0);
      checks++; if (timed_out != 0 || got_data.size() != 1) begin errors++; $display("FAIL mrst_new_count got=%0d want=1", got_data.size()); end
      checks++; if (lat != 2) begin errors++; $display("FAIL mrst_new_latency got=%0d want=2", lat); end
      if (got_data.size() == 1) begin
         checks++; if (got_data[0] !== model_mem[7] || got_resp[0] !== 2'b00 || got_last[0] !== 1'b1) begin
            errors++; $display("FAIL mrst_new_beat got=%h/%b/%b want=%h/00/1", got_data[0], got_resp[0], got_last[0], model_mem[7]); end
      end
   endtask

   initial begin
      test_reset();
      preload_all();
      test_incr_basic();
      test_wrap();
      test_backpressure();
      test_boundary();
      test_rsvd_burst();
      test_preload_read_first();
      test_random();
      test_mid_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog time limit reached errors=%0d checks=%0d", errors, checks);
      $fatal(1);
   end

endmodule
